// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin share of the iomem bus between CPU (m0) and a second master (m1); 1-cycle arbitration, then pass-through.
// Grant held until iomem_ready (completion to the owner only); define IOMEM_TIMEOUT_EN for a watchdog that force-completes stalled transfers.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic        w_grant_nxt;
    logic        r_last_grant;
    logic        w_last_grant_nxt;

    logic        w_busy;
    logic        w_sel_valid;
    logic        w_done;
    logic        w_expire;
    logic        w_complete;
    logic [31:0] w_rdata;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
        $error("iomem_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    assign w_busy      = (r_state == ST_BUSY);
    assign w_sel_valid = r_grant ? m1_valid : m0_valid;

    // Owner's fields go straight through; masters hold them stable until ready.
    assign iomem_valid = w_busy && w_sel_valid;
    assign iomem_wstrb = r_grant ? m1_wstrb : m0_wstrb;
    assign iomem_addr  = r_grant ? m1_addr  : m0_addr;
    assign iomem_wdata = r_grant ? m1_wdata : m0_wdata;

    assign w_done = iomem_valid && iomem_ready;

`ifdef IOMEM_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || !w_busy) begin
            r_cnt <= '0;
        end else if (!iomem_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A real ready in the expiry cycle wins over the forced completion.
    assign w_expire    = iomem_valid && !iomem_ready && (r_cnt == CNT_LAST);
    assign timeout_err = w_expire;
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_complete = w_done || w_expire;
    assign w_rdata    = w_expire ? TIMEOUT_RDATA : iomem_rdata;

    assign m0_ready = w_complete && !r_grant;
    assign m1_ready = w_complete &&  r_grant;
    assign m0_rdata = m0_ready ? w_rdata : 32'h0;
    assign m1_rdata = m1_ready ? w_rdata : 32'h0;

    assign grant = r_grant;
    assign busy  = w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_grant_nxt = ~r_last_grant;
                    w_state_nxt = ST_BUSY;
                end else if (m0_valid) begin
                    w_grant_nxt = 1'b0;
                    w_state_nxt = ST_BUSY;
                end else if (m1_valid) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Owner withdrawing its request aborts without touching fairness history.
                if (!w_sel_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_complete) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter: per-requester expectation queues filled at drive time, drained on mN_ready.
module tb_iomem_arbiter;

    localparam logic [31:0] K        = 32'h1134_5678;
    localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;
    localparam logic [31:0] A0       = 32'h0300_0100;
    localparam logic [31:0] A1       = 32'h0700_0200;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        iomem_valid, iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic        grant, busy, timeout_err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    int p_lat   = 1;
    bit p_stall = 1'b0;
    int p_cnt   = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e_mon;
    int          glog[$];
    int          clog[$];
    logic [31:0] alog[$];

    int nb, d0, d1;

    always #5 clk = ~clk;

    iomem_arbiter #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_RDATA  (TO_RDATA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_valid    (m0_valid),
        .m0_ready    (m0_ready),
        .m0_wstrb    (m0_wstrb),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_ready    (m1_ready),
        .m1_wstrb    (m1_wstrb),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_rdata    (m1_rdata),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Peripheral: answers p_lat cycles after iomem_valid rises, data derived from the address.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!iomem_valid || iomem_ready) p_cnt <= 0;
        else                             p_cnt <= p_cnt + 1;
    end
    assign iomem_ready = iomem_valid && !p_stall && (p_cnt == p_lat - 1);
    assign iomem_rdata = iomem_addr ^ K;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input logic [3:0] ws, input logic [31:0] a,
                                    input logic [31:0] wd, input logic to);
        exp_t e;
        e.addr  = a;
        e.wstrb = ws;
        e.wdata = wd;
        e.to    = to;
        e.rdata = to ? TO_RDATA : (a ^ K);
        return e;
    endfunction

    always @(negedge clk) begin
        if (m0_ready) begin
            chk("m1_ready_with_m0", m1_ready, 1'b0);
            chk("m1_rdata_not_owner", m1_rdata, 32'h0);
            if (q0.size() == 0) begin
                chk("m0_ready_unexpected", m0_ready, 1'b0);
            end else begin
                e_mon = q0.pop_front();
                chk("m0_rdata", m0_rdata, e_mon.rdata);
                chk("m0_addr", iomem_addr, e_mon.addr);
                chk("m0_wstrb", iomem_wstrb, e_mon.wstrb);
                chk("m0_wdata", iomem_wdata, e_mon.wdata);
                chk("m0_timeout_err", timeout_err, e_mon.to);
            end
            glog.push_back(int'(grant));
            alog.push_back(iomem_addr);
            clog.push_back(cyc);
        end
        if (m1_ready) begin
            chk("m0_rdata_not_owner", m0_rdata, 32'h0);
            if (q1.size() == 0) begin
                chk("m1_ready_unexpected", m1_ready, 1'b0);
            end else begin
                e_mon = q1.pop_front();
                chk("m1_rdata", m1_rdata, e_mon.rdata);
                chk("m1_addr", iomem_addr, e_mon.addr);
                chk("m1_wstrb", iomem_wstrb, e_mon.wstrb);
                chk("m1_wdata", iomem_wdata, e_mon.wdata);
                chk("m1_timeout_err", timeout_err, e_mon.to);
            end
            glog.push_back(int'(grant));
            alog.push_back(iomem_addr);
            clog.push_back(cyc);
        end
    end

    // Called and returns just after a rising edge; solo=1 also checks the bus fields every valid cycle.
    task automatic txn(input int id, input logic [3:0] ws, input logic [31:0] a,
                       input logic [31:0] wd, input logic to, input bit solo, output int n_valid);
        bit got = 1'b0;
        n_valid = 0;
        if (id == 0) begin
            m0_valid = 1'b1; m0_wstrb = ws; m0_addr = a; m0_wdata = wd;
            q0.push_back(mk_exp(ws, a, wd, to));
        end else begin
            m1_valid = 1'b1; m1_wstrb = ws; m1_addr = a; m1_wdata = wd;
            q1.push_back(mk_exp(ws, a, wd, to));
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (solo && iomem_valid) begin
                n_valid++;
                chk("txn_bus_wstrb", iomem_wstrb, ws);
                chk("txn_bus_addr", iomem_addr, a);
                chk("txn_bus_wdata", iomem_wdata, wd);
            end
            got = (id == 0) ? m0_ready : m1_ready;
        end
        chk("txn_completed", got, 1'b1);
        @(posedge clk);
        #1;
        if (id == 0) m0_valid = 1'b0;
        else         m1_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL global_time_limit: got running want finished");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_iomem_valid", iomem_valid, 1'b0);
        chk("rst_m0_ready", m0_ready, 1'b0);
        chk("rst_m1_ready", m1_ready, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single m0 read: latency and completion pulse.
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0000; m0_wdata = 32'h0;
        q0.push_back(mk_exp(4'h0, 32'h0300_0000, 32'h0, 1'b0));
        @(negedge clk);
        chk("t1_valid_in_arb_cycle", iomem_valid, 1'b0);
        chk("t1_busy_in_arb_cycle", busy, 1'b0);
        @(negedge clk);
        chk("t1_valid_rise", iomem_valid, 1'b1);
        chk("t1_m0_ready", m0_ready, 1'b1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_ready", m1_ready, 1'b0);
        @(posedge clk);
        #1 m0_valid = 1'b0;
        @(negedge clk);
        chk("t1_busy_fall", busy, 1'b0);
        chk("t1_m0_ready_once", m0_ready, 1'b0);

        // Both masters continuously valid from reset: alternating grants, one idle cycle apart.
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        glog.delete(); alog.delete(); clog.delete();
        fork
            begin
                txn(0, 4'h0, A0, 32'h0, 1'b0, 1'b0, d0);
                txn(0, 4'h0, A0, 32'h0, 1'b0, 1'b0, d0);
            end
            begin
                txn(1, 4'h0, A1, 32'h0, 1'b0, 1'b0, d1);
                txn(1, 4'h0, A1, 32'h0, 1'b0, 1'b0, d1);
            end
        join
        chk("t2_completions", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk("t2_grant_seq", glog[i], i % 2);
            chk("t2_addr_seq", alog[i], (i % 2 == 1) ? A1 : A0);
            if (i > 0) chk("t2_cycles_between", clog[i] - clog[i-1], 2);
        end

        // m1 write with a 5-cycle peripheral.
        p_lat = 5;
        txn(1, 4'b0011, 32'h0700_0004, 32'hA5A5_0000, 1'b0, 1'b1, nb);
        chk("t3_busy_cycles", nb, 5);
        @(negedge clk);
        chk("t3_ready_single", m1_ready, 1'b0);
        chk("t3_idle_after", busy, 1'b0);
        p_lat = 1;

        // Owner drops valid mid-transaction: abort, no ready, fairness history kept.
        @(posedge clk);
        #1;
        p_stall = 1'b1;
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0010;
        @(posedge clk);
        #1 m0_valid = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 1'b1);
        chk("ab_iomem_valid", iomem_valid, 1'b0);
        chk("ab_no_ready", m0_ready, 1'b0);
        @(negedge clk);
        chk("ab_back_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        p_stall = 1'b0;
        glog.delete();
        fork
            txn(0, 4'h0, A0, 32'h0, 1'b0, 1'b0, d0);
            txn(1, 4'h0, A1, 32'h0, 1'b0, 1'b0, d1);
        join
        chk("ab_tie_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("ab_tie_first", glog[0], 0);
            chk("ab_tie_second", glog[1], 1);
        end
        txn(0, 4'h0, A0 + 32'h4, 32'h0, 1'b0, 1'b0, d0);

        // Reset during the 3rd busy cycle of an m0 transaction.
        p_stall = 1'b1;
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0020;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t4_busy_before_reset", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("t4_iomem_valid", iomem_valid, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_no_m0_ready", m0_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        p_stall = 1'b0;
        glog.delete();
        fork
            txn(0, 4'h0, 32'h0300_0020, 32'h0, 1'b0, 1'b0, d0);
            txn(1, 4'h0, A1, 32'h0, 1'b0, 1'b0, d1);
        join
        chk("t4_tie_count", glog.size(), 2);
        if (glog.size() > 0) chk("t4_first_tie_m0", glog[0], 0);

`ifdef IOMEM_TIMEOUT_EN
        // Peripheral never answers: forced completion in the 8th busy cycle.
        p_stall = 1'b1;
        txn(0, 4'h0, 32'h0300_0030, 32'h0, 1'b1, 1'b1, nb);
        chk("t5_busy_cycles", nb, 8);
        @(negedge clk);
        chk("t5_idle_after", busy, 1'b0);
        chk("t5_err_one_cycle", timeout_err, 1'b0);
        @(posedge clk);
        #1;
        // Ready lands exactly in the expiry cycle: normal completion wins.
        p_stall = 1'b0;
        p_lat = 8;
        txn(0, 4'h0, 32'h1134_562D, 32'h0, 1'b0, 1'b1, nb);
        chk("t6_busy_cycles", nb, 8);
        p_lat = 1;
`endif

        repeat (2) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Two-requester arbiter that shares the single iomem peripheral bus (valid/ready, wstrb, addr, wdata, rdata) between the CPU iomem port (requester 0) and a second bus master, e.g. a DMA or blitter engine (requester 1).
- Sits between the masters and the peripheral address decode / ready mux.
- Grants are round-robin and held for a full transaction until ready.
- An optional watchdog completes transactions that a stalled peripheral never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 1024, BUSY cycles allowed before forced completion (only with IOMEM_TIMEOUT_EN); legal range 2..65535.
- TIMEOUT_RDATA, 32'h0000_0000, read data returned to the requester on a timed-out transaction.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- m0_valid  input  1  requester 0 request
- m0_ready  output  1  requester 0 completion strobe
- m0_wstrb  input  4  requester 0 byte write strobes (0 = read)
- m0_addr  input  32  requester 0 address
- m0_wdata  input  32  requester 0 write data
- m0_rdata  output  32  requester 0 read data
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: same directions and widths as m0, for requester 1
- iomem_valid  output  1  request to peripheral bus
- iomem_ready  input  1  peripheral completion
- iomem_wstrb  output  4  muxed strobes
- iomem_addr  output  32  muxed address
- iomem_wdata  output  32  muxed write data
- iomem_rdata  input  32  peripheral read data
- grant  output  1  current owner (0/1); meaningful only while busy
- busy  output  1  transaction in flight
- timeout_err  output  1  one-cycle pulse on forced completion

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - State = IDLE, grant = 0, last_grant = 1 (so requester 0 wins the first tie).
  - busy = 0, iomem_valid = 0, m0_ready = m1_ready = 0, timeout_err = 0, timeout counter = 0.
- States: IDLE, BUSY.
- IDLE:
  - If exactly one mN_valid is high, grant <= N and go to BUSY.
  - If both are high, grant <= ~last_grant and go to BUSY.
  - If neither is high, stay in IDLE.
  - iomem_valid = 0; all mN_ready = 0.
- BUSY:
  - iomem_valid = m[grant]_valid (combinational).
  - iomem_wstrb/addr/wdata = fields of m[grant] (combinational pass-through; masters hold their fields stable until ready).
  - When iomem_valid && iomem_ready:
    - m[grant]_ready = 1 in the same cycle, m[grant]_rdata = iomem_rdata.
    - last_grant <= grant; go to IDLE.
- Non-granted requester: ready = 0, rdata = 32'h0. In IDLE both rdata = 0.
- Latency:
  - Request seen in IDLE at cycle T; iomem_valid high at T+1; ready is passed through combinationally.
  - Minimum transaction is 2 cycles (arbitration + 1-cycle peripheral).
  - One IDLE cycle always separates back-to-back transactions.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Granted requester drops valid in BUSY (protocol violation): abort to IDLE next cycle, no ready issued, last_grant unchanged.
- reset asserted mid-transaction: next cycle is IDLE with iomem_valid = 0; the in-flight transaction is discarded without ready.
- busy = (state == BUSY); grant is registered.

Optional Feature:
- Macro: IOMEM_TIMEOUT_EN.
- Enabled:
  - Counter of width clog2(TIMEOUT_CYCLES+1), cleared in IDLE and incremented each BUSY cycle without iomem_ready.
  - If the counter reaches TIMEOUT_CYCLES-1 and iomem_ready is still low in that cycle:
    - m[grant]_ready = 1 with m[grant]_rdata = TIMEOUT_RDATA.
    - timeout_err pulses for 1 cycle; state goes to IDLE; last_grant <= grant.
  - iomem_ready arriving in the same cycle as expiry wins: normal completion, no timeout_err.
- Disabled:
  - No counter; BUSY waits indefinitely for iomem_ready.
  - timeout_err tied to 0.

Test Plan:
- Reset, then m0 reads addr 32'h0300_0000 while the peripheral returns 32'h1234_5678 with ready one cycle after iomem_valid → iomem_valid rises 1 cycle after m0_valid; m0_ready pulses once with m0_rdata = 32'h1234_5678; m1_ready stays 0; busy falls the next cycle.
- m0 and m1 both valid in the same cycle from reset, continuously, with a 1-cycle peripheral → grant sequence 0,1,0,1; iomem_addr alternates between the m0_addr and m1_addr values; one IDLE cycle between transactions.
- m1 writes wstrb 4'b0011, wdata 32'hA5A5_0000 to 32'h0700_0004 with ready after 5 cycles → iomem_wstrb/addr/wdata match m1 for all 5 BUSY cycles; m1_ready high exactly one cycle.
- reset asserted on the 3rd BUSY cycle of an m0 transaction → iomem_valid = 0 and busy = 0 on the next cycle; no m0_ready; first tie after reset is granted to m0.
- IOMEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and TIMEOUT_RDATA=32'hDEAD_BEEF, peripheral never ready → m0_ready and timeout_err pulse in the 8th BUSY cycle; m0_rdata = 32'hDEAD_BEEF; then IDLE.
- IOMEM_TIMEOUT_EN with TIMEOUT_CYCLES=8, iomem_ready arriving in exactly the 8th BUSY cycle with rdata 32'h55 → normal completion with rdata 32'h55; timeout_err stays 0.
